// File: rtl/dino_pkg.sv
// Shared definitions for the dino game datapath: obstacle codes, LFSR reset value
// and the seven-segment glyphs used by the track/display stage.
package dino_pkg;

  typedef enum logic [1:0] {
    OBS_NONE   = 2'b00,
    OBS_CACTUS = 2'b01,
    OBS_BIRD   = 2'b10
  } obs_e;

  localparam logic [15:0] LFSR_RESET = 16'hACE1;

  // Active-low segments, bit order gfedcba.
  localparam logic [6:0] HEX_BLANK  = 7'b1111111;
  localparam logic [6:0] HEX_CACTUS = 7'b1111001;
  localparam logic [6:0] HEX_BIRD   = 7'b1011100;
  localparam logic [6:0] HEX_DINO   = 7'b0100011;

endpackage

// File: rtl/obstacle_spawner_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), shifting left with feedback into bit 0.
// A load of zero is replaced by LFSR_RESET so the register never locks up.
module lfsr16
  import dino_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adv,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] q
);

  logic [15:0] q_q, q_d;
  logic        fb;

  always_comb begin
    fb  = q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10];
    q_d = q_q;
    if (load) begin
      q_d = (load_val == 16'd0) ? LFSR_RESET : load_val;
    end else if (adv) begin
      q_d = {q_q[14:0], fb};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= LFSR_RESET;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/obstacle_spawner.sv
// Obstacle spawner feeding the HEX scrolling track: one registered strobe per game tick.
// Birds are only produced when OBSTACLE_SPAWNER_BIRD_EN is defined; otherwise every spawn is a cactus.
module obstacle_spawner
  import dino_pkg::*;
#(
  parameter int MIN_GAP     = 3,
  parameter int MAX_GAP     = 8,
  parameter int LEAD_IN     = 4,
  parameter int THRESH_INIT = 64,
  parameter int THRESH_MAX  = 192,
  parameter int RAMP_EVERY  = 5
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        tick,
  input  logic        run,
  input  logic [15:0] seed,
  input  logic        seed_load,
  output logic        obs_valid,
  output logic [1:0]  obs_type,
  output logic [15:0] spawn_count
);

  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_RUN} state_e;

  localparam logic [7:0] THR_INIT = 8'(THRESH_INIT);
  localparam logic [7:0] THR_MAX  = 8'(THRESH_MAX);

  state_e      state_q, state_d;
  logic [3:0]  gap_q, gap_d;
  logic [3:0]  empty_q, empty_d;
  logic [7:0]  lead_q, lead_d;
  logic [7:0]  ramp_q, ramp_d;
  logic [7:0]  thr_q, thr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        vld_q, vld_d;
  logic [1:0]  typ_q, typ_d;
  logic [15:0] lfsr;
  logic        adv;
  logic        lfsr_unused;

  // Never lowers a threshold that already starts above the ceiling, and never wraps.
  function automatic logic [7:0] thr_bump(input logic [7:0] t);
    logic [8:0] sum;
    logic [8:0] ceil;
    sum  = {1'b0, t} + 9'd8;
    ceil = (t > THR_MAX) ? {1'b0, t} : {1'b0, THR_MAX};
    return (sum > ceil) ? ceil[7:0] : sum[7:0];
  endfunction

  lfsr16 u_lfsr (
    .clk      (CLOCK_50),
    .rst_n    (RESET_N),
    .adv      (adv),
    .load     (seed_load),
    .load_val (seed),
    .q        (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:8];

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    empty_d = empty_q;
    lead_d  = lead_q;
    ramp_d  = ramp_q;
    thr_d   = thr_q;
    cnt_d   = cnt_q;
    vld_d   = 1'b0;
    typ_d   = typ_q;
    adv     = 1'b0;

    if (!run) begin
      state_d = S_IDLE;
      typ_d   = OBS_NONE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_LEAD;
          lead_d  = '0;
          cnt_d   = '0;
          thr_d   = THR_INIT;
          ramp_d  = '0;
          empty_d = '0;
          gap_d   = '0;
          typ_d   = OBS_NONE;
        end
        S_LEAD: begin
          if (tick) begin
            vld_d = 1'b1;
            typ_d = OBS_NONE;
            adv   = 1'b1;
            if (lead_q == 8'(LEAD_IN - 1)) state_d = S_RUN;
            else                           lead_d  = lead_q + 8'd1;
          end
        end
        S_RUN: begin
          if (tick) begin
            vld_d = 1'b1;
            adv   = 1'b1;
            // Decision uses the LFSR value from before this tick's advance.
            if (gap_q != 4'd0) begin
              typ_d = OBS_NONE;
              gap_d = gap_q - 4'd1;
            end else if (empty_q == 4'(MAX_GAP - 1) || lfsr[7:0] < thr_q) begin
`ifdef OBSTACLE_SPAWNER_BIRD_EN
              typ_d = lfsr[8] ? OBS_BIRD : OBS_CACTUS;
`else
              typ_d = OBS_CACTUS;
`endif
              gap_d   = 4'(MIN_GAP);
              empty_d = '0;
              if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
              if (ramp_q == 8'(RAMP_EVERY - 1)) begin
                ramp_d = '0;
                thr_d  = thr_bump(thr_q);
              end else begin
                ramp_d = ramp_q + 8'd1;
              end
            end else begin
              typ_d   = OBS_NONE;
              empty_d = empty_q + 4'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      empty_q <= '0;
      lead_q  <= '0;
      ramp_q  <= '0;
      thr_q   <= THR_INIT;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      typ_q   <= OBS_NONE;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      empty_q <= empty_d;
      lead_q  <= lead_d;
      ramp_q  <= ramp_d;
      thr_q   <= thr_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      typ_q   <= typ_d;
    end
  end

  assign obs_valid   = vld_q;
  assign obs_type    = typ_q;
  assign spawn_count = cnt_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Bench for obstacle_spawner: three parameterisations driven in lockstep against a
// spawn-rule reference model; bird checks follow OBSTACLE_SPAWNER_BIRD_EN.
module tb_obstacle_spawner;

  logic        clk = 1'b0;
  logic        rst_n, tick, run, seed_load;
  logic [15:0] seed;
  logic        vld [3];
  logic [1:0]  typ [3];
  logic [15:0] cnt [3];

  always #5 clk = ~clk;

  obstacle_spawner d0 (
    .CLOCK_50(clk), .RESET_N(rst_n), .tick(tick), .run(run), .seed(seed),
    .seed_load(seed_load), .obs_valid(vld[0]), .obs_type(typ[0]), .spawn_count(cnt[0]));

  obstacle_spawner #(.THRESH_INIT(255)) d1 (
    .CLOCK_50(clk), .RESET_N(rst_n), .tick(tick), .run(run), .seed(seed),
    .seed_load(seed_load), .obs_valid(vld[1]), .obs_type(typ[1]), .spawn_count(cnt[1]));

  obstacle_spawner #(.THRESH_INIT(0)) d2 (
    .CLOCK_50(clk), .RESET_N(rst_n), .tick(tick), .run(run), .seed(seed),
    .seed_load(seed_load), .obs_valid(vld[2]), .obs_type(typ[2]), .spawn_count(cnt[2]));

  localparam int MIN_GAP = 3, MAX_GAP = 8, LEAD_IN = 4, RAMP_EVERY = 5, TMAX = 192;
  int init_thr [3] = '{64, 255, 0};

  // Reference model: mode 0 idle, 1 lead-in, 2 running.
  logic [15:0] m_lfsr [3];
  int          mode [3], lead_n [3], since [3], spawns [3];
  logic        m_vld [3];
  logic [1:0]  m_typ [3];

  int n_tests = 0, n_fail = 0;
  int birds = 0;
  int str2 = 0;
  int q2 [$];

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    logic fb;
    fb = l[15] ^ l[13] ^ l[12] ^ l[10];
    return {l[14:0], fb};
  endfunction

  // Threshold after n spawns: +8 every RAMP_EVERY spawns, capped, never below its start.
  function automatic int m_thr(input int init, input int n);
    int t, cap;
    t   = init + 8 * (n / RAMP_EVERY);
    cap = (init > TMAX) ? init : TMAX;
    return (t > cap) ? cap : t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input int i);
    logic [15:0] l;
    logic        adv;
    int          thr;
    l = m_lfsr[i];
    adv = 1'b0;
    m_vld[i] = 1'b0;
    if (!rst_n) begin
      m_lfsr[i] = 16'hACE1; mode[i] = 0; m_typ[i] = 2'b00; spawns[i] = 0;
      lead_n[i] = 0; since[i] = MIN_GAP;
      return;
    end
    if (!run) begin
      mode[i] = 0; m_typ[i] = 2'b00;
    end else if (mode[i] == 0) begin
      mode[i] = 1; lead_n[i] = 0; spawns[i] = 0; since[i] = MIN_GAP; m_typ[i] = 2'b00;
    end else if (tick) begin
      m_vld[i] = 1'b1;
      adv = 1'b1;
      if (mode[i] == 1) begin
        m_typ[i] = 2'b00;
        lead_n[i]++;
        if (lead_n[i] == LEAD_IN) mode[i] = 2;
      end else begin
        thr = m_thr(init_thr[i], spawns[i]);
        if (since[i] >= MIN_GAP &&
            (since[i] - MIN_GAP == MAX_GAP - 1 || int'(l[7:0]) < thr)) begin
`ifdef OBSTACLE_SPAWNER_BIRD_EN
          m_typ[i] = l[8] ? 2'b10 : 2'b01;
`else
          m_typ[i] = 2'b01;
`endif
          spawns[i]++;
          since[i] = 0;
        end else begin
          m_typ[i] = 2'b00;
          since[i]++;
        end
      end
    end
    if (seed_load)  m_lfsr[i] = (seed == 16'd0) ? 16'hACE1 : seed;
    else if (adv)   m_lfsr[i] = lfsr_next(l);
  endtask

  task automatic step(input logic r_n, input logic t, input logic r,
                      input logic sl, input logic [15:0] sd);
    int sat;
    @(negedge clk);
    rst_n = r_n; tick = t; run = r; seed_load = sl; seed = sd;
    for (int i = 0; i < 3; i++) model_edge(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      sat = (spawns[i] > 65535) ? 65535 : spawns[i];
      chk($sformatf("vld%0d", i), 32'(vld[i]), 32'(m_vld[i]));
      chk($sformatf("typ%0d", i), 32'(typ[i]), 32'(m_typ[i]));
      chk($sformatf("cnt%0d", i), 32'(cnt[i]), sat);
      if (vld[i] && typ[i] == 2'b10) birds++;
    end
    chk("thr0", 32'(d0.thr_q), m_thr(init_thr[0], spawns[0]));
    chk("thr1", 32'(d1.thr_q), m_thr(init_thr[1], spawns[1]));
    chk("thr2", 32'(d2.thr_q), m_thr(init_thr[2], spawns[2]));
    chk("lfsr", 32'(d0.lfsr), 32'(m_lfsr[0]));
    if (vld[2]) begin
      if (typ[2] != 2'b00) q2.push_back(str2 - LEAD_IN);
      str2++;
    end
  endtask

  function automatic int q2_at(input int k);
    return (q2.size() > k) ? q2[k] : -1;
  endfunction

  initial begin
    rst_n = 1'b0; tick = 1'b0; run = 1'b0; seed_load = 1'b0; seed = 16'd0;
    for (int i = 0; i < 3; i++) begin
      m_lfsr[i] = 16'hACE1; mode[i] = 0; lead_n[i] = 0; since[i] = MIN_GAP;
      spawns[i] = 0; m_vld[i] = 1'b0; m_typ[i] = 2'b00;
    end

    // Reset state
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    chk("rst_lfsr", 32'(d0.lfsr), 32'h0000ACE1);
    chk("rst_vld",  32'(vld[0]), 0);
    chk("rst_cnt",  32'(cnt[0]), 0);

    // Zero seed guard, then seed 1 advancing to 2
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    chk("seed0", 32'(d0.lfsr), 32'h0000ACE1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0001);
    chk("seed1", 32'(d0.lfsr), 32'h00000001);
    str2 = 0; q2.delete();
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'd0);
    chk("seed1_adv", 32'(d0.lfsr), 32'h00000002);
    chk("lead_typ0", 32'(typ[0]), 0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 16'd0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 16'd0);
      chk("lead_vld", 32'(vld[0]), 1);
      chk("lead_typ", 32'(typ[0]), 0);
    end
    chk("lead_cnt", 32'(cnt[0]), 0);

    // Forced-spawn cadence on the never-spawn instance
    for (int k = 0; k < 40; k++) step(1'b1, 1'b1, 1'b1, 1'b0, 16'd0);
    chk("force_t0", q2_at(0), 7);
    chk("force_t1", q2_at(1), 18);
    chk("force_t2", q2_at(2), 29);

    // Seed load coinciding with a tick
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234);
    chk("seed_tick_vld", 32'(vld[0]), 1);
    chk("seed_tick_lfsr", 32'(d0.lfsr), 32'h00001234);

    // run dropped together with a tick
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    chk("drop_vld", 32'(vld[0]), 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    chk("idle_vld", 32'(vld[0]), 0);
    chk("idle_typ", 32'(typ[0]), 0);

    // Re-raise: lead-in again, then a long uninterrupted run to exercise the ramp
    step(1'b1, 1'b0, 1'b1, 1'b1, 16'($urandom));
    for (int k = 0; k < LEAD_IN; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 16'd0);
      chk("relead_typ", 32'(typ[0]), 0);
    end
    for (int k = 0; k < 900; k++) step(1'b1, 1'b1, 1'b1, 1'b0, 16'd0);
    if (spawns[0] >= 80) chk("thr_sat", 32'(d0.thr_q), 192);
    chk("thr_clamp255", 32'(d1.thr_q), 255);

    // Reset mid-operation cancels the strobe
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'd0);
    chk("midrst_vld", 32'(vld[0]), 0);
    chk("midrst_cnt", 32'(cnt[0]), 0);

    // Randomised traffic
    for (int k = 0; k < 2000; k++)
      step(($urandom_range(0, 1499) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 999) != 0), ($urandom_range(0, 49) == 0), 16'($urandom));

`ifndef OBSTACLE_SPAWNER_BIRD_EN
    chk("no_birds", birds, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/obstacle_spawner.md
Name: obstacle_spawner

Overview:
- Upstream feeder for the HEX scrolling track. On every game tick it decides what enters the rightmost column (HEX0): nothing, a cactus, or a bird.
- Uses a 16-bit LFSR for randomness. Enforces minimum and maximum obstacle spacing so every pattern stays jumpable, and ramps spawn density as obstacles accumulate.
- Output is a one-cycle strobe plus a type code, consumed by the track shifter/collision stage.

Parameters:
- MIN_GAP, 3, minimum empty ticks between two obstacles (1..15).
- MAX_GAP, 8, forced spawn once this many consecutive empty ticks elapse (> MIN_GAP, <= 15).
- LEAD_IN, 4, empty ticks emitted after entering run before any spawn is allowed.
- THRESH_INIT, 64, initial spawn threshold compared against LFSR[7:0].
- THRESH_MAX, 192, threshold ceiling.
- RAMP_EVERY, 5, spawns between threshold increments of 8.

Ports:
- CLOCK_50  in  1  system clock.
- RESET_N  in  1  synchronous active-low reset.
- tick  in  1  single-cycle game-tick strobe.
- run  in  1  1 = game active; 0 = idle/game over.
- seed  in  16  LFSR seed value.
- seed_load  in  1  load seed into LFSR this cycle.
- obs_valid  out  1  one-cycle strobe, one per processed tick.
- obs_type  out  2  00 none, 01 cactus, 10 bird, 11 never driven.
- spawn_count  out  16  obstacles spawned since leaving IDLE; saturates at 16'hFFFF.

Behaviour:
- Clock and reset: single clock CLOCK_50. Reset is synchronous, active-low on RESET_N.
- Reset values: LFSR=16'hACE1, state=IDLE, obs_valid=0, obs_type=00, spawn_count=0, gap_cnt=0, empty_cnt=0, threshold=THRESH_INIT, ramp_cnt=0.
- LFSR: Fibonacci form, taps 16,14,13,11. Shifts left with feedback into bit 0.
  - Advances exactly once per tick while state is LEAD or RUN.
  - seed_load has priority over advance. A loaded value of 0 is replaced by 16'hACE1.
- FSM:
  - IDLE: outputs held low.
    - run=1 → LEAD. Clear lead counter, spawn_count, threshold, ramp_cnt, empty_cnt, gap_cnt.
  - LEAD: each tick emits obs_valid=1, obs_type=00.
    - After LEAD_IN ticks → RUN.
  - RUN: each tick emits obs_valid=1 with a decided type.
  - Any state with run=0 → IDLE next cycle. No strobe is emitted on that cycle, even if tick=1.
- Latency: obs_valid/obs_type are registered and assert the cycle after tick. obs_valid deasserts the following cycle.
  - obs_type holds its value until the next strobe.
- Spawn decision in RUN (uses the pre-advance LFSR value):
  - If gap_cnt != 0: type=00, gap_cnt decrements.
  - Else if empty_cnt == MAX_GAP-1 or LFSR[7:0] < threshold: spawn.
    - Type is 10 if LFSR[8]=1, else 01.
    - gap_cnt=MIN_GAP, empty_cnt=0.
  - Else: type=00, empty_cnt increments.
  - Consequence: a spawn is guaranteed within MAX_GAP ticks, and no spawn occurs within MIN_GAP ticks of the previous one.
- Ramp: on each spawn, ramp_cnt increments.
  - When ramp_cnt reaches RAMP_EVERY, it clears and threshold += 8, saturating at THRESH_MAX.
  - Threshold arithmetic is 9-bit internally, clamped to 8 bits.
- Simultaneous events:
  - tick with run falling edge: no strobe.
  - seed_load with tick: seed loads and the tick still produces a strobe using the pre-load LFSR value; no advance that cycle.
- Reset mid-operation: returns to IDLE on the next edge, with any pending strobe cancelled.

Optional Feature:
- Macro: OBSTACLE_SPAWNER_BIRD_EN.
- Defined: birds are produced as described above.
- Undefined: every spawn is cactus (01), LFSR[8] is ignored, and obs_type never equals 10.

Decomposition:
- Shared package `dino_pkg` holds:
  - the obs_type codes OBS_NONE/OBS_CACTUS/OBS_BIRD;
  - LFSR_RESET = 16'hACE1;
  - the HEX glyph constants shared with the track/display stage.
- One sub-module `lfsr16`: inputs clk, rst_n, adv, load, load_val; output q. It contains the zero-seed guard.
- The FSM, counters and decision logic stay in obstacle_spawner.

Test Plan:
- Reset, then run=1 with 4 ticks → four strobes, each with obs_type=00; FSM in RUN afterwards; spawn_count=0.
- Force always-spawn with THRESH_INIT=255, MIN_GAP=3 → obstacles appear on RUN ticks 0, 4, 8, 12 (three 00 strobes between each); spawn_count=4.
- Force never-spawn with THRESH_INIT=0, MAX_GAP=8 → forced spawn on RUN tick 7, then every 11th tick (MIN_GAP 3 plus 8).
- seed_load with seed=0 → LFSR reads 16'hACE1. seed=16'h0001 → after 1 advance LFSR reads 16'h0002.
- RAMP_EVERY=5, THRESH_INIT=255 clamp check and THRESH_INIT=64 → threshold 72 after spawn 5, saturating at 192 after spawn 80.
- run dropped in the same cycle as tick → no obs_valid strobe; IDLE next cycle. Re-raise run → LEAD_IN of 4 empty strobes again. Build without OBSTACLE_SPAWNER_BIRD_EN → 1000 RUN ticks produce zero obs_type=10.
